// File: rtl/pp_buffer_ctrl_gen2_pkg.sv
`default_nettype none
// =============================================================================
// Package  : pp_buffer_pkg
// Brief    : Shared types and width helper for the ping-pong buffer controller.
// Revision : 2.0
// =============================================================================
package pp_buffer_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} pp_state_t;
    typedef enum logic {BANK_EMPTY, BANK_FULL} bank_status_t;
    typedef enum logic {RD_SEQ, RD_TRANSPOSE} rd_mode_t;

    // Counter/address width, never narrower than one bit.
    function automatic int calc_aw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pp_buffer_ctrl_gen2_rd_addr_gen.sv
`default_nettype none
// =============================================================================
// Module   : pp_rd_addr_gen
// Brief    : Drain address generator, sequential or row/column transpose.
// Revision : 2.0
// =============================================================================
module pp_rd_addr_gen
    import pp_buffer_pkg::*;
#(
    parameter int BLOCK_LEN = 192,
    parameter int ROWS      = 16,
    parameter int AW        = calc_aw(BLOCK_LEN)
)(
    input  logic          clk,
    input  logic          resetN,
    input  logic          start,
    input  logic          advance,
    input  logic          mode,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int             COLS   = BLOCK_LEN / ROWS;
    localparam int             RW     = calc_aw(ROWS);
    localparam logic [AW-1:0]  c_LAST = AW'(BLOCK_LEN - 1);
    localparam logic [RW-1:0]  c_RMAX = RW'(ROWS - 1);
    localparam logic [AW-1:0]  c_COLS = AW'(COLS);

    logic [AW-1:0] r_cnt;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_col;
    logic [RW-1:0] r_row;
    rd_mode_t      r_mode;

    // All counters sit at zero at block start, so address 0 is correct in
    // either order even before the new mode is latched.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cnt  <= '0;
            r_base <= '0;
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= RD_SEQ;
        end else begin
            if (start) begin
                r_mode <= rd_mode_t'(mode);
            end
            if (advance) begin
                if (last) begin
                    r_cnt  <= '0;
                    r_base <= '0;
                    r_col  <= '0;
                    r_row  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_row == c_RMAX) begin
                        r_row  <= '0;
                        r_base <= '0;
                        r_col  <= r_col + 1'b1;
                    end else begin
                        r_row  <= r_row + 1'b1;
                        r_base <= r_base + c_COLS;
                    end
                end
            end
        end
    end

    assign last = (r_cnt == c_LAST);
    assign addr = (r_mode == RD_TRANSPOSE) ? (r_base + r_col) : r_cnt;

endmodule
`default_nettype wire

// File: rtl/pp_buffer_ctrl_gen2.sv
`default_nettype none
// =============================================================================
// Module   : pp_buffer_ctrl_gen2
// Brief    : Ping-pong controller for two single-port RAM banks with
//            valid/ready streams and sequential or transpose drain order.
// Revision : 2.0
// =============================================================================
module pp_buffer_ctrl_gen2
    import pp_buffer_pkg::*;
#(
    parameter int DATA_W         = 1,
    parameter int BLOCK_LEN      = 192,
    parameter int ROWS           = 16,
    parameter int CLEAR_ON_RESET = 1,
    parameter int AW             = calc_aw(BLOCK_LEN)
)(
    input  logic              clk,
    input  logic              resetN,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              rd_mode,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              a_en,
    output logic              b_en,
    output logic              a_we,
    output logic              b_we,
    output logic [AW-1:0]     a_addr,
    output logic [AW-1:0]     b_addr,
    output logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] b_wdata,
    input  logic [DATA_W-1:0] a_q,
    input  logic [DATA_W-1:0] b_q
);

    localparam logic [1:0]    c_ST_IDLE  = IDLE;
    localparam logic [1:0]    c_ST_CLEAR = CLEAR;
    localparam logic [1:0]    c_ST_RUN   = RUN;
    localparam logic [AW-1:0] c_LAST     = AW'(BLOCK_LEN - 1);

    logic [1:0]        r_state;
    logic [AW-1:0]     r_wr_cnt;
    logic              r_wr_sel;
    logic              r_rd_sel;
    bank_status_t      r_stat [2];
    logic              r_draining;
    logic              r_inflight;
    logic              r_inflight_bank;
    logic              r_inflight_last;
    logic [1:0]        r_skid_cnt;
    logic [DATA_W-1:0] r_sk0_data;
    logic [DATA_W-1:0] r_sk1_data;
    logic              r_sk0_last;
    logic              r_sk1_last;

    logic              w_run;
    logic              w_clear;
    logic              w_wr;
    logic              w_wr_last;
    logic              w_start;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic [AW-1:0]     w_rd_addr;
    logic              w_rd_last;
    logic [DATA_W-1:0] w_ret_data;

    assign w_run     = (r_state == c_ST_RUN);
    assign w_clear   = (r_state == c_ST_CLEAR);
    assign s_ready   = w_run && (r_stat[r_wr_sel] == BANK_EMPTY);
    assign w_wr      = s_valid && s_ready;
    assign w_wr_last = w_wr && (r_wr_cnt == c_LAST);
    assign w_start   = w_run && !r_draining && (r_stat[r_rd_sel] == BANK_FULL);
    assign w_pop     = m_valid && m_ready;

    // A word popped this cycle frees its slot, which keeps 1 word/cycle flowing.
    assign w_occ   = 3'(r_skid_cnt) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = (r_draining || w_start) && (w_occ < 3'd2);

    pp_rd_addr_gen #(
        .BLOCK_LEN (BLOCK_LEN),
        .ROWS      (ROWS),
        .AW        (AW)
    ) u_rd_addr_gen (
        .clk     (clk),
        .resetN  (resetN),
        .start   (w_start),
        .advance (w_issue),
        .mode    (rd_mode),
        .addr    (w_rd_addr),
        .last    (w_rd_last)
    );

    always_comb begin
        a_en    = 1'b0;
        a_we    = 1'b0;
        a_addr  = '0;
        a_wdata = '0;
        b_en    = 1'b0;
        b_we    = 1'b0;
        b_addr  = '0;
        b_wdata = '0;
        if (w_clear) begin
            a_en   = 1'b1;
            a_we   = 1'b1;
            a_addr = r_wr_cnt;
            b_en   = 1'b1;
            b_we   = 1'b1;
            b_addr = r_wr_cnt;
        end else begin
            if (w_wr) begin
                if (!r_wr_sel) begin
                    a_en    = 1'b1;
                    a_we    = 1'b1;
                    a_addr  = r_wr_cnt;
                    a_wdata = s_data;
                end else begin
                    b_en    = 1'b1;
                    b_we    = 1'b1;
                    b_addr  = r_wr_cnt;
                    b_wdata = s_data;
                end
            end
            // The read bank is FULL and the write bank EMPTY, so they never collide.
            if (w_issue) begin
                if (!r_rd_sel) begin
                    a_en   = 1'b1;
                    a_addr = w_rd_addr;
                end else begin
                    b_en   = 1'b1;
                    b_addr = w_rd_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= c_ST_IDLE;
            r_wr_cnt   <= '0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_stat[0]  <= BANK_EMPTY;
            r_stat[1]  <= BANK_EMPTY;
            r_draining <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_state <= (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_RUN;
                end
                c_ST_CLEAR: begin
                    if (r_wr_cnt == c_LAST) begin
                        r_wr_cnt <= '0;
                        r_state  <= c_ST_RUN;
                    end else begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (w_wr) begin
                        r_wr_cnt <= w_wr_last ? '0 : (r_wr_cnt + 1'b1);
                    end
                    if (w_wr_last) begin
                        r_stat[r_wr_sel] <= BANK_FULL;
                        r_wr_sel         <= ~r_wr_sel;
                    end
                    if (w_start) begin
                        r_draining <= 1'b1;
                    end
                    if (w_issue && w_rd_last) begin
                        r_draining       <= 1'b0;
                        r_stat[r_rd_sel] <= BANK_EMPTY;
                        r_rd_sel         <= ~r_rd_sel;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_ret_data = r_inflight_bank ? b_q : a_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_inflight      <= 1'b0;
            r_inflight_bank <= 1'b0;
            r_inflight_last <= 1'b0;
            r_skid_cnt      <= '0;
            r_sk0_data      <= '0;
            r_sk1_data      <= '0;
            r_sk0_last      <= 1'b0;
            r_sk1_last      <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_bank <= r_rd_sel;
            r_inflight_last <= w_issue && w_rd_last;
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_skid_cnt == 2'd0) begin
                        r_sk0_data <= w_ret_data;
                        r_sk0_last <= r_inflight_last;
                    end else begin
                        r_sk1_data <= w_ret_data;
                        r_sk1_last <= r_inflight_last;
                    end
                    r_skid_cnt <= r_skid_cnt + 2'd1;
                end
                2'b01: begin
                    r_sk0_data <= r_sk1_data;
                    r_sk0_last <= r_sk1_last;
                    r_skid_cnt <= r_skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_skid_cnt == 2'd1) begin
                        r_sk0_data <= w_ret_data;
                        r_sk0_last <= r_inflight_last;
                    end else begin
                        r_sk0_data <= r_sk1_data;
                        r_sk0_last <= r_sk1_last;
                        r_sk1_data <= w_ret_data;
                        r_sk1_last <= r_inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_valid = (r_skid_cnt != 2'd0);
    assign m_data  = r_sk0_data;
    assign m_last  = m_valid && r_sk0_last;

endmodule
`default_nettype wire
